// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, the "no producer" tag, the bus
// record snooped by reservation stations, and the micro-op encodings.
package cdb_pkg;

  localparam int CDB_DATA_W = 16;
  localparam int CDB_TAG_W  = 3;

  // Tag 0 marks an operand with no pending producer; it never appears on the bus.
  localparam logic [CDB_TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

  typedef enum logic [2:0] {
    UFOP_NOP  = 3'b000,
    UFOP_ADD  = 3'b001,
    UFOP_SLT  = 3'b010,
    UFOP_CMP  = 3'b011,
    UFOP_ADD4 = 3'b100,
    UFOP_SUB4 = 3'b101
  } ufop_e;

  // Every micro-op except NOP produces a result that must be broadcast.
  function automatic logic ufop_broadcasts(ufop_e op);
    return op != UFOP_NOP;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: returns a one-hot grant for the
// first asserted request at or after ptr_i, wrapping modulo N.
module rr_priority_picker #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  int   idx;
  logic found;

  // Scan N positions starting at the pointer and keep only the first hit.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one functional unit per cycle and registers
// its result/tag onto the CDB. Round-robin by default; defining
// CDB_FIXED_PRIORITY_EN switches to fixed priority (lowest index wins) and
// removes the rotating pointer. CHECK_TAG0 enables a simulation-only check
// that flags requests carrying the reserved tag 0.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int DATA_W     = CDB_DATA_W,
  parameter int TAG_W      = CDB_TAG_W,
  parameter bit CHECK_TAG0 = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ*TAG_W-1:0]  req_tag_i,
  input  logic                    cdb_stall_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    cdb_valid_o,
  output logic [DATA_W-1:0]       cdb_data_o,
  output logic [TAG_W-1:0]        cdb_tag_o
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } bus_t;

  bus_t             bus_q, bus_d;
  logic [N_REQ-1:0] req_ok;
  logic [N_REQ-1:0] pick;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic             any_grant;

  // A request carrying tag 0 is a protocol error and is never eligible.
  always_comb begin
    req_ok = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ok[i] = req_i[i] && (req_tag_i[i*TAG_W +: TAG_W] != TAG_W'(TAG_NONE));
    end
  end

`ifdef CDB_FIXED_PRIORITY_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;

  // Next pointer sits just past the winner so it becomes lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) begin
      ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Rotating-priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  rr_priority_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i   (req_ok),
    .ptr_i   (ptr),
    .grant_o (pick)
  );

  // Grant is suppressed during reset and stall; pending requests simply wait.
  assign grant_o   = (rst || cdb_stall_i) ? '0 : pick;
  assign any_grant = |grant_o;

  // Encode the one-hot grant into an index for the data/tag mux.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_o[i]) win_idx = PTR_W'(i);
    end
  end

  // Capture the winner, drop valid when idle, hold everything under stall.
  always_comb begin
    bus_d = bus_q;
    if (!cdb_stall_i) begin
      if (any_grant) begin
        bus_d.valid = 1'b1;
        bus_d.tag   = req_tag_i[win_idx*TAG_W +: TAG_W];
        bus_d.data  = req_data_i[win_idx*DATA_W +: DATA_W];
      end else begin
        bus_d.valid = 1'b0;
      end
    end
  end

  // CDB output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_q <= '0;
    else     bus_q <= bus_d;
  end

  assign cdb_valid_o = bus_q.valid;
  assign cdb_data_o  = bus_q.data;
  assign cdb_tag_o   = bus_q.tag;

`ifndef SYNTHESIS
  if (CHECK_TAG0) begin : g_tag0_chk
    for (genvar g = 0; g < N_REQ; g++) begin : g_fu
      a_no_tag0: assert property (@(posedge clk) disable iff (rst)
        !(req_i[g] && (req_tag_i[g*TAG_W +: TAG_W] == TAG_W'(TAG_NONE))))
        else $error("cdb_arbiter: FU %0d requests broadcast with tag 0", g);
    end
  end
`endif

endmodule
